// File: rtl/gecko_load_store_sequencer_pkg.sv
// Shared types and lane helpers for the gecko load/store sequencer: load tags,
// memory request bundle, misalignment detection and store/load lane alignment.
package gecko_load_store_sequencer_pkg;

  typedef logic [4:0] rv32_reg_addr_t;
  typedef logic [1:0] gecko_byte_offset_t;

  typedef enum logic [2:0] {
    RV32I_FUNCT3_LS_B  = 3'b000,
    RV32I_FUNCT3_LS_H  = 3'b001,
    RV32I_FUNCT3_LS_W  = 3'b010,
    RV32I_FUNCT3_LS_BU = 3'b100,
    RV32I_FUNCT3_LS_HU = 3'b101
  } rv32i_funct3_ls_t;

  typedef struct packed {
    rv32_reg_addr_t     rd_addr;
    gecko_byte_offset_t offset;
    rv32i_funct3_ls_t   op;
  } gecko_load_tag_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } gecko_mem_request_t;

  // Undefined funct3 encodings fall through to byte width everywhere below.
  function automatic logic gecko_is_misaligned(gecko_byte_offset_t addr,
                                               rv32i_funct3_ls_t op);
    case (op)
      RV32I_FUNCT3_LS_H, RV32I_FUNCT3_LS_HU: return addr[0];
      RV32I_FUNCT3_LS_W:                     return addr != 2'b00;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic gecko_mem_request_t gecko_get_store_result(logic [31:0] addr,
                                                                rv32i_funct3_ls_t op,
                                                                logic [31:0] value);
    gecko_mem_request_t req;
    req.addr = {addr[31:2], 2'b00};
    req.we   = 1'b1;
    case (op)
      RV32I_FUNCT3_LS_H, RV32I_FUNCT3_LS_HU: begin
        req.mask  = 4'b0011 << addr[1:0];
        req.wdata = {16'h0, value[15:0]} << {addr[1:0], 3'b000};
      end
      RV32I_FUNCT3_LS_W: begin
        req.mask  = 4'b1111;
        req.wdata = value;
      end
      default: begin
        req.mask  = 4'b0001 << addr[1:0];
        req.wdata = {24'h0, value[7:0]} << {addr[1:0], 3'b000};
      end
    endcase
    return req;
  endfunction

  function automatic logic [31:0] gecko_get_load_result(logic [31:0] data,
                                                        gecko_byte_offset_t offset,
                                                        rv32i_funct3_ls_t op);
    logic [31:0] lane;
    lane = data >> {offset, 3'b000};
    case (op)
      RV32I_FUNCT3_LS_H:  return {{16{lane[15]}}, lane[15:0]};
      RV32I_FUNCT3_LS_HU: return {16'h0, lane[15:0]};
      RV32I_FUNCT3_LS_W:  return lane;
      RV32I_FUNCT3_LS_BU: return {24'h0, lane[7:0]};
      default:            return {{24{lane[7]}}, lane[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/gecko_load_store_sequencer_tag_fifo.sv
// In-order tag FIFO for outstanding loads; depth must be a power of two so the
// pointers wrap naturally.
module gecko_load_tag_fifo
  import gecko_load_store_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  gecko_load_tag_t        push_tag,
  input  logic                   pop,
  output gecko_load_tag_t        pop_tag,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  gecko_load_tag_t  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    pop_tag = mem_q[rd_ptr_q];
    empty   = (count_q == '0);
    count   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/gecko_load_store_sequencer.sv
// Load/store sequencer between execute and a single in-order data-memory port:
// one request register, a tag FIFO for outstanding loads and one writeback register.
module gecko_load_store_sequencer
  import gecko_load_store_sequencer_pkg::*;
#(
  parameter int MAX_LOADS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_store,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_value,
  input  logic [4:0]  cmd_rd_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_mask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_value,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        idle
);

  localparam int               CNT_W   = $clog2(MAX_LOADS) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOADS);

  logic [CNT_W-1:0]   tag_count;
  logic               fifo_empty;
  gecko_load_tag_t    push_tag, pop_tag;
  logic               tag_push, tag_pop;
  rv32i_funct3_ls_t   cmd_op;
  logic               cmd_misaligned, cmd_fire, cmd_issue, rsp_fire;
  gecko_mem_request_t store_req;

  logic               mem_req_valid_q, mem_req_valid_d;
  gecko_mem_request_t mem_req_q, mem_req_d;
  logic               wb_valid_q, wb_valid_d;
  rv32_reg_addr_t     wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0]        wb_rd_value_q, wb_rd_value_d;
  logic               fault_valid_q, fault_valid_d;
  logic [31:0]        fault_addr_q, fault_addr_d;

  always_comb begin
    cmd_op         = rv32i_funct3_ls_t'(cmd_funct3);
    cmd_misaligned = gecko_is_misaligned(cmd_addr[1:0], cmd_op);
    // Registered tag_count only: a tag retiring this cycle frees its slot next cycle.
    cmd_ready      = (!mem_req_valid_q || mem_req_ready) && (cmd_store || tag_count < MAX_CNT);
    cmd_fire       = cmd_valid && cmd_ready;
    cmd_issue      = cmd_fire && !cmd_misaligned;
    tag_push       = cmd_issue && !cmd_store;
    push_tag       = '{rd_addr: cmd_rd_addr, offset: cmd_addr[1:0], op: cmd_op};
    store_req      = gecko_get_store_result(cmd_addr, cmd_op, cmd_value);

    mem_rsp_ready  = !wb_valid_q || wb_ready;
    rsp_fire       = mem_rsp_valid && mem_rsp_ready && !fifo_empty;
    tag_pop        = rsp_fire;

    mem_req_valid_d = mem_req_valid_q;
    mem_req_d       = mem_req_q;
    if (cmd_issue) begin
      mem_req_valid_d = 1'b1;
      if (cmd_store) mem_req_d = store_req;
      else mem_req_d = '{addr: {cmd_addr[31:2], 2'b00}, we: 1'b0, mask: 4'b0000, wdata: 32'h0};
    end else if (mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    wb_valid_d    = wb_valid_q;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_rd_value_d = wb_rd_value_q;
    if (rsp_fire) begin
      wb_valid_d    = 1'b1;
      wb_rd_addr_d  = pop_tag.rd_addr;
      wb_rd_value_d = gecko_get_load_result(mem_rsp_data, pop_tag.offset, pop_tag.op);
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end

    fault_valid_d = cmd_fire && cmd_misaligned;
    fault_addr_d  = fault_valid_d ? cmd_addr : fault_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid_q <= 1'b0;
      mem_req_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_addr_q    <= '0;
      wb_rd_value_q   <= '0;
      fault_valid_q   <= 1'b0;
      fault_addr_q    <= '0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_q       <= mem_req_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_rd_value_q   <= wb_rd_value_d;
      fault_valid_q   <= fault_valid_d;
      fault_addr_q    <= fault_addr_d;
    end
  end

  gecko_load_tag_fifo #(.DEPTH(MAX_LOADS)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .pop_tag  (pop_tag),
    .empty    (fifo_empty),
    .count    (tag_count)
  );

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_q.addr;
  assign mem_req_we    = mem_req_q.we;
  assign mem_req_mask  = mem_req_q.mask;
  assign mem_req_wdata = mem_req_q.wdata;
  assign wb_valid      = wb_valid_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_rd_value   = wb_rd_value_q;
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;
  assign idle          = !mem_req_valid_q && (tag_count == '0) && !wb_valid_q;

  // A response with no outstanding tag has no destination and is dropped.
  a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rsp_valid && fifo_empty));

endmodule

// File: tb/tb_gecko_load_store_sequencer.sv
// Directed bench for gecko_load_store_sequencer with hand-computed expectations.
module tb_gecko_load_store_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_addr, cmd_value;
  logic [4:0]  cmd_rd_addr;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_mask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_value;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100;

  always #5 clk = ~clk;

  gecko_load_store_sequencer #(.MAX_LOADS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_funct3(cmd_funct3), .cmd_addr(cmd_addr), .cmd_value(cmd_value),
    .cmd_rd_addr(cmd_rd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_mask(mem_req_mask), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr),
    .wb_rd_value(wb_rd_value),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] v, input logic [4:0] rd);
    cmd_store   = st;
    cmd_funct3  = f3;
    cmd_addr    = a;
    cmd_value   = v;
    cmd_rd_addr = rd;
    cmd_valid   = 1'b1;
  endtask

  task automatic send_cmd(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] v, input logic [4:0] rd);
    set_cmd(st, f3, a, v, rd);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_funct3 = 3'b000;
    cmd_addr = '0; cmd_value = '0; cmd_rd_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; wb_ready = 1'b1;
    repeat (3) tick();
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_fault_valid", 32'(fault_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_wb_value", wb_rd_value, 32'h0);
    rst_n = 1'b1;
    tick();

    // Store byte to the top lane
    set_cmd(1'b1, F_B, 32'h0000_1003, 32'h1122_3344, 5'd0);
    #1 chk("sb_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("sb_req_valid", 32'(mem_req_valid), 32'd1);
    chk("sb_req_addr", mem_req_addr, 32'h0000_1000);
    chk("sb_req_we", 32'(mem_req_we), 32'd1);
    chk("sb_req_mask", 32'(mem_req_mask), 32'h8);
    chk("sb_req_wdata", mem_req_wdata, 32'h4400_0000);
    mem_req_ready = 1'b1;
    tick();
    chk("sb_req_done", 32'(mem_req_valid), 32'd0);
    chk("sb_no_wb", 32'(wb_valid), 32'd0);
    chk("sb_idle", 32'(idle), 32'd1);

    // Store halfword to upper half, request accepted the cycle it appears
    send_cmd(1'b1, F_H, 32'h0000_1002, 32'hCAFE_1234, 5'd0);
    chk("sh_req_mask", 32'(mem_req_mask), 32'hC);
    chk("sh_req_wdata", mem_req_wdata, 32'h1234_0000);
    tick();
    mem_req_ready = 1'b0;

    // LH with sign extension from the upper half
    send_cmd(1'b0, F_H, 32'h0000_2002, 32'h0, 5'd5);
    chk("lh_req_addr", mem_req_addr, 32'h0000_2000);
    chk("lh_req_we", 32'(mem_req_we), 32'd0);
    chk("lh_req_mask", 32'(mem_req_mask), 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("lh_tag_pending", 32'(idle), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h8001_1234;
    #1 chk("lh_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    tick();
    mem_rsp_valid = 1'b0;
    chk("lh_wb_valid", 32'(wb_valid), 32'd1);
    chk("lh_wb_rd", 32'(wb_rd_addr), 32'd5);
    chk("lh_wb_value", wb_rd_value, 32'hFFFF_8001);
    tick();
    chk("lh_wb_drop", 32'(wb_valid), 32'd0);
    chk("lh_idle", 32'(idle), 32'd1);

    // LBU from lane 1, rd=0 still written back
    mem_req_ready = 1'b1;
    send_cmd(1'b0, F_BU, 32'h0000_3001, 32'h0, 5'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_AB00;
    tick();
    mem_rsp_valid = 1'b0;
    chk("lbu_wb_valid", 32'(wb_valid), 32'd1);
    chk("lbu_wb_rd0", 32'(wb_rd_addr), 32'd0);
    chk("lbu_wb_value", wb_rd_value, 32'h0000_00AB);
    tick();

    // Fill all load slots, stores still flow, one response reopens loads
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b0, F_W, 32'h0000_5000 + 32'(4 * i), 32'h0, 5'(i + 1));
      #1 chk($sformatf("full_accept%0d", i), 32'(cmd_ready), 32'd1);
      tick();
    end
    set_cmd(1'b0, F_W, 32'h0000_5200, 32'h0, 5'd20);
    #1 chk("full_load_blocked", 32'(cmd_ready), 32'd0);
    set_cmd(1'b1, F_W, 32'h0000_5100, 32'h5555_AAAA, 5'd0);
    #1 chk("full_store_ok", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("full_store_wdata", mem_req_wdata, 32'h5555_AAAA);
    tick();
    set_cmd(1'b0, F_W, 32'h0000_5200, 32'h0, 5'd20);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0101_0101;
    #1 chk("full_no_bypass", 32'(cmd_ready), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1 chk("full_reopen", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    chk("full_wb_rd1", 32'(wb_rd_addr), 32'd1);
    chk("full_wb_val1", wb_rd_value, 32'h0101_0101);
    for (int i = 1; i < 4; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = {4{8'(i + 1)}};
      tick();
      chk($sformatf("drain_rd%0d", i), 32'(wb_rd_addr), 32'(i + 1));
      chk($sformatf("drain_val%0d", i), wb_rd_value, {4{8'(i + 1)}});
    end
    mem_rsp_valid = 1'b0;
    tick();
    chk("drain_idle", 32'(idle), 32'd1);

    // Misaligned word with one load outstanding
    send_cmd(1'b0, F_W, 32'h0000_6000, 32'h0, 5'd9);
    set_cmd(1'b0, F_W, 32'h0000_4002, 32'h0, 5'd3);
    #1 chk("mis_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("mis_fault_valid", 32'(fault_valid), 32'd1);
    chk("mis_fault_addr", fault_addr, 32'h0000_4002);
    chk("mis_no_req", 32'(mem_req_valid), 32'd0);
    send_cmd(1'b0, F_H, 32'h0000_6001, 32'h0, 5'd4);
    chk("mis_h_fault", fault_addr, 32'h0000_6001);
    tick();
    chk("mis_pulse_end", 32'(fault_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("mis_wb_rd", 32'(wb_rd_addr), 32'd9);
    chk("mis_wb_val", wb_rd_value, 32'hDEAD_BEEF);
    tick();
    chk("mis_no_tag", 32'(idle), 32'd1);

    // Writeback backpressure, then reset mid-stream
    send_cmd(1'b0, F_W, 32'h0000_7000, 32'h0, 5'd10);
    send_cmd(1'b0, F_W, 32'h0000_7004, 32'h0, 5'd11);
    tick();
    wb_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA_0001;
    tick();
    mem_rsp_data = 32'hBBBB_0002;
    #1 chk("bp_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    tick();
    chk("bp_wb_valid", 32'(wb_valid), 32'd1);
    chk("bp_wb_rd", 32'(wb_rd_addr), 32'd10);
    chk("bp_wb_stable", wb_rd_value, 32'hAAAA_0001);
    rst_n = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("mrst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mrst_fault", 32'(fault_valid), 32'd0);
    chk("mrst_idle", 32'(idle), 32'd1);
    chk("mrst_wb_value", wb_rd_value, 32'h0);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    tick();
    chk("post_rst_idle", 32'(idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
